// File: rtl/mul_arbiter_pkg.sv
// Shared multiplier parameters, tag type and reduction helpers for the
// round-robin multiplier front end.
package mul_arbiter_pkg;

  localparam int DATA_WIDTH    = 12;
  localparam int Q_INT         = 3329;
  localparam logic [DATA_WIDTH-1:0] Q = DATA_WIDTH'(Q_INT);
  localparam int MUL_STAGE_CNT = 3;
  localparam bit MULTYPE_KRED  = 1'b0;
  localparam int Q_K           = 13;
  localparam int KRED_L        = 2;
  localparam int KRED_MUL      = (Q_K ** KRED_L) % Q_INT;
  localparam int PROD_W        = 2 * DATA_WIDTH;

  // -Q^-1 mod 2^DATA_WIDTH (Q^-1 mod 4096 is 769)
  localparam logic [DATA_WIDTH-1:0] QINV_NEG = 12'd3327;

  // Sized for the largest supported requester count (8)
  localparam int ID_W = 3;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } mul_tag_t;

  function automatic logic [DATA_WIDTH-1:0] mont_reduce(input logic [PROD_W-1:0] p);
    logic [DATA_WIDTH-1:0] m;
    logic [PROD_W:0]       t;
    logic [DATA_WIDTH:0]   u;
    m = p[DATA_WIDTH-1:0] * QINV_NEG;
    t = {1'b0, p} + ((PROD_W+1)'(m) * (PROD_W+1)'(Q));
    u = t[PROD_W:DATA_WIDTH];
    return (u >= {1'b0, Q}) ? DATA_WIDTH'(u - {1'b0, Q}) : u[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] kred_mul(input logic [PROD_W-1:0] p);
    logic [PROD_W-1:0] t;
    t = (p % PROD_W'(Q_INT)) * PROD_W'(KRED_MUL);
    return DATA_WIDTH'(t % PROD_W'(Q_INT));
  endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Requester-side bus of the multiplier arbiter: operand handshake,
// freeze control and tagged result strobes.
interface mul_arbiter_if
  import mul_arbiter_pkg::*;
#(
  parameter int REQ_CNT = 3
);
  logic                               hold;
  logic [REQ_CNT-1:0]                 req_valid;
  logic [REQ_CNT-1:0][DATA_WIDTH-1:0] req_a;
  logic [REQ_CNT-1:0][DATA_WIDTH-1:0] req_b;
  logic [REQ_CNT-1:0]                 req_ready;
  logic [REQ_CNT-1:0]                 rsp_valid;
  logic [DATA_WIDTH-1:0]              rsp_data;
  logic                               busy;

  modport master (
    output hold, req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  hold, req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/mul_arbiter_mo_mul.sv
// Pipelined modular multiplier: one product stage, then reduction and
// delay stages for a total of MUL_STAGE_CNT registers (needs >= 2).
module mo_mul
  import mul_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] r
);
  logic [PROD_W-1:0]                        prod_r;
  logic [DATA_WIDTH-1:0]                    red_s;
  logic [MUL_STAGE_CNT-2:0][DATA_WIDTH-1:0] res_r;

  // Reduction of the registered product into the selected domain
  always_comb begin
    red_s = '0;
    if (MULTYPE_KRED) begin
      red_s = kred_mul(prod_r);
    end else begin
      red_s = mont_reduce(prod_r);
    end
  end

  // Product register followed by the reduced-result delay line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_r <= '0;
      res_r  <= '0;
    end else begin
      prod_r   <= PROD_W'(a) * PROD_W'(b);
      res_r[0] <= red_s;
      for (int k = 1; k < MUL_STAGE_CNT - 1; k++) begin
        res_r[k] <= res_r[k-1];
      end
    end
  end

  assign r = res_r[MUL_STAGE_CNT-2];

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin front end sharing one pipelined mo_mul between REQ_CNT
// requesters; results return tagged after a fixed 1+MUL_STAGE_CNT cycles.
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int REQ_CNT = 3
)(
  input logic          clk,
  input logic          rst,
  mul_arbiter_if.slave bus
);
  localparam int TAG_DEPTH = 1 + MUL_STAGE_CNT;

  logic [ID_W-1:0]                ptr_r;
  logic [ID_W-1:0]                ptr_nxt_s;
  logic [ID_W:0]                  pick_s;
  logic                           grant_s;
  logic [ID_W-1:0]                grant_id_s;
  logic [REQ_CNT-1:0]             ready_s;
  logic [DATA_WIDTH-1:0]          sel_a_s;
  logic [DATA_WIDTH-1:0]          sel_b_s;
  logic [DATA_WIDTH-1:0]          op_a_r;
  logic [DATA_WIDTH-1:0]          op_b_r;
  logic [DATA_WIDTH-1:0]          mul_res_s;
  mul_tag_t                       tail_s;
  mul_tag_t                       head_s;
  mul_tag_t [TAG_DEPTH-1:0]       tag_r;
  logic [REQ_CNT-1:0]             rsp_valid_s;
  logic                           busy_s;

  // Rotate the request vector so ptr sits at bit 0, take the lowest set bit,
  // then rotate the offset back. Returns {found, id}.
  function automatic logic [ID_W:0] rr_pick(input logic [REQ_CNT-1:0] v,
                                            input logic [ID_W-1:0]    p);
    logic [2*REQ_CNT-1:0] rot;
    logic [ID_W:0]        off;
    logic [ID_W:0]        sum;
    logic                 found;
    rot   = {v, v} >> p;
    found = 1'b0;
    off   = '0;
    for (int k = REQ_CNT - 1; k >= 0; k--) begin
      found = found | rot[k];
      off   = rot[k] ? (ID_W+1)'(k) : off;
    end
    sum = {1'b0, p} + off;
    sum = (sum >= (ID_W+1)'(REQ_CNT)) ? sum - (ID_W+1)'(REQ_CNT) : sum;
    return {found, sum[ID_W-1:0]};
  endfunction

  // Grant selection, operand mux and next pointer
  always_comb begin
    pick_s     = rr_pick(bus.req_valid, ptr_r);
    grant_s    = rst & ~bus.hold & pick_s[ID_W];
    grant_id_s = pick_s[ID_W-1:0];
    ready_s    = '0;
    sel_a_s    = '0;
    sel_b_s    = '0;
    for (int i = 0; i < REQ_CNT; i++) begin
      ready_s[i] = grant_s && (grant_id_s == ID_W'(i));
      sel_a_s    = sel_a_s | ({DATA_WIDTH{ready_s[i]}} & bus.req_a[i]);
      sel_b_s    = sel_b_s | ({DATA_WIDTH{ready_s[i]}} & bus.req_b[i]);
    end
    tail_s.valid = grant_s;
    tail_s.id    = grant_s ? grant_id_s : '0;
    if (grant_s) begin
      ptr_nxt_s = (grant_id_s == ID_W'(REQ_CNT - 1)) ? '0 : grant_id_s + ID_W'(1);
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Priority pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  // Issue register; idle slots keep the old operands and are discarded
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a_r <= '0;
      op_b_r <= '0;
    end else if (grant_s) begin
      op_a_r <= sel_a_s;
      op_b_r <= sel_b_s;
    end else begin
      op_a_r <= op_a_r;
      op_b_r <= op_b_r;
    end
  end

  // Tag pipe shifts every cycle in lockstep with the multiplier
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_r <= '0;
    end else begin
      tag_r <= {tag_r[TAG_DEPTH-2:0], tail_s};
    end
  end

  mo_mul u_mul (
    .clk (clk),
    .rst (rst),
    .a   (op_a_r),
    .b   (op_b_r),
    .r   (mul_res_s)
  );

  // Response decode from the tag-pipe head and in-flight summary
  always_comb begin
    head_s      = tag_r[TAG_DEPTH-1];
    busy_s      = 1'b0;
    rsp_valid_s = '0;
    for (int k = 0; k < TAG_DEPTH; k++) begin
      busy_s = busy_s | tag_r[k].valid;
    end
    for (int i = 0; i < REQ_CNT; i++) begin
      rsp_valid_s[i] = head_s.valid && (head_s.id == ID_W'(i));
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_data  = mul_res_s;
  assign bus.busy      = busy_s;

endmodule

// File: tb/tb_mul_arbiter.sv
// Randomized scoreboard bench for mul_arbiter against a round-robin and
// modular-arithmetic reference model.
module tb_mul_arbiter;
  import mul_arbiter_pkg::*;

  localparam int N   = 3;
  localparam int LAT = 1 + MUL_STAGE_CNT;
  localparam int QI  = Q_INT;

  typedef struct {
    int id;
    int data;
    int issue;
    int due;
  } exp_t;

  logic clk;
  logic rst;

  mul_arbiter_if #(.REQ_CNT(N)) bus ();

  mul_arbiter #(.REQ_CNT(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   rinv     = 0;
  int   ptr_m    = 0;
  int   reload_pct = 0;
  bit   rst_lvl  = 1'b0;
  bit   hold_v   = 1'b0;
  bit   pv[N];
  int   pa[N];
  int   pb[N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference product: a*b*R^-1 mod Q (Montgomery) or a*b*Q_K^KRED_L mod Q
  function automatic int golden(input int a, input int b);
    longint p;
    longint k;
    p = (longint'(a) * longint'(b)) % QI;
    if (MULTYPE_KRED) begin
      k = 1;
      for (int i = 0; i < KRED_L; i++) k = (k * Q_K) % QI;
      return int'((p * k) % QI);
    end
    return int'((p * rinv) % QI);
  endfunction

  task automatic newreq(input int i);
    pv[i] = 1'b1;
    pa[i] = int'($urandom_range(QI - 1));
    pb[i] = int'($urandom_range(QI - 1));
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = pv[i];
      bus.req_a[i]     = DATA_WIDTH'(pa[i]);
      bus.req_b[i]     = DATA_WIDTH'(pb[i]);
    end
    bus.hold = hold_v;
  endtask

  // Expected grant for this cycle from the round-robin rule
  task automatic model_cycle();
    int g;
    int idx;
    exp_t e;
    g = -1;
    if (rst && !hold_v) begin
      for (int k = 0; k < N; k++) begin
        idx = (ptr_m + k) % N;
        if (g < 0 && pv[idx]) g = idx;
      end
    end
    chk("req_ready", longint'(bus.req_ready), (g >= 0) ? longint'(1 << g) : 0);
    if (g >= 0) begin
      e.id    = g;
      e.data  = golden(pa[g], pb[g]);
      e.issue = cyc;
      e.due   = cyc + LAT;
      sb_q.push_back(e);
      ptr_m = (g + 1) % N;
      pv[g] = 1'b0;
      if (int'($urandom_range(99)) < reload_pct) newreq(g);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst_lvl) begin
      rst = 1'b0;
      sb_q.delete();
      ptr_m = 0;
      #1;
      chk("busy_in_reset", longint'(bus.busy), 0);
      chk("rsp_in_reset", longint'(bus.rsp_valid), 0);
    end else begin
      rst = 1'b1;
    end
    drive();
    @(negedge clk);
    model_cycle();
  endtask

  // Scoreboard monitor: every response must match the oldest due entry
  always @(negedge clk) begin : monitor
    exp_t e;
    int   bexp;
    bexp = 0;
    foreach (sb_q[k]) begin
      if (sb_q[k].issue < cyc && sb_q[k].due >= cyc) bexp = 1;
    end
    chk("busy", longint'(bus.busy), bexp);
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      chk("rsp_valid", longint'(bus.rsp_valid), longint'(1 << e.id));
      chk("rsp_data", longint'(bus.rsp_data), e.data);
    end else begin
      chk("rsp_idle", longint'(bus.rsp_valid), 0);
    end
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b0;
      pa[i] = 0;
      pb[i] = 0;
    end
    drive();
    for (int x = 1; x < QI; x++) begin
      if (((longint'(1) << DATA_WIDTH) * x) % QI == 1) rinv = x;
    end
    #2 rst = 1'b0;

    rst_lvl = 1'b0;
    repeat (2) step();
    rst_lvl = 1'b1;

    // Single request a=1, b=1 from requester 0
    pv[0] = 1'b1; pa[0] = 1; pb[0] = 1;
    reload_pct = 0;
    repeat (LAT + 3) step();

    // All three continuously valid for 9 cycles, starting from ptr 0
    rst_lvl = 1'b0; step(); rst_lvl = 1'b1;
    for (int i = 0; i < N; i++) newreq(i);
    reload_pct = 100;
    repeat (9) step();
    reload_pct = 0;
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    repeat (LAT + 1) step();

    // Hold pulse over cycles 3..5 with requesters 1 and 2 valid
    newreq(1); newreq(2);
    reload_pct = 100;
    for (int c = 0; c < 9; c++) begin
      hold_v = (c >= 3 && c <= 5);
      step();
    end
    hold_v = 1'b0;
    reload_pct = 0;
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    repeat (LAT + 1) step();

    // Reset with four products in flight; next grant goes to lowest valid
    for (int i = 0; i < N; i++) newreq(i);
    reload_pct = 100;
    repeat (4) step();
    reload_pct = 0;
    pv[0] = 1'b0; newreq(1); newreq(2);
    rst_lvl = 1'b0; step(); rst_lvl = 1'b1;
    repeat (LAT + 4) step();
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    repeat (LAT + 1) step();

    // Random traffic with random hold and occasional reset pulses
    reload_pct = 50;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && int'($urandom_range(99)) < 40) newreq(i);
      end
      hold_v  = (int'($urandom_range(99)) < 10);
      rst_lvl = !(int'($urandom_range(199)) == 0);
      step();
    end
    rst_lvl = 1'b1;
    hold_v  = 1'b0;
    reload_pct = 0;
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    repeat (LAT + 1) step();

    // Requester 1 alone: a over 0..Q-1, then b over 0..Q-1, back to back
    for (int a = 0; a < QI; a++) begin
      pv[1] = 1'b1; pa[1] = a; pb[1] = QI - 1 - a;
      step();
    end
    for (int b = 0; b < QI; b++) begin
      pv[1] = 1'b1; pa[1] = QI - 1; pb[1] = b;
      step();
    end
    pv[1] = 1'b0;
    repeat (LAT + 3) step();
    chk("drain_empty", longint'(sb_q.size()), 0);
    chk("busy_idle", longint'(bus.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin front end that shares one pipelined `mo_mul` modular multiplier between `REQ_CNT` requesters, e.g. NTT butterfly, point-wise multiply and twiddle pre-scale. It accepts at most one operand pair per cycle and tags each issued product with its requester ID. It returns the result on a shared data bus with a per-requester valid strobe after a fixed latency. It sits between the polynomial-arithmetic controllers and the single multiplier instance.

## Interface
- `REQ_CNT`, 3: number of requesters, 2..8.
- `DATA_WIDTH`, `MUL_STAGE_CNT`: taken from the shared package; not overridden here.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `hold`  in  1  freeze issuance; in-flight products still drain.
- `req_valid`  in  [REQ_CNT]  operand pair valid.
- `req_a`, `req_b`  in  [REQ_CNT][DATA_WIDTH]  operands, each < Q.
- `req_ready`  out  [REQ_CNT]  grant; one-hot or zero.
- `rsp_valid`  out  [REQ_CNT]  result strobe; one-hot or zero.
- `rsp_data`  out  DATA_WIDTH  multiplier result, unmodified `mo_mul` domain.
- `busy`  out  1  any product in flight.

## Operation
- Handshake: requester i transfers on `req_valid[i] && req_ready[i]`.
  - `req_ready` is combinational from `req_valid`, `hold` and the priority pointer.
  - A requester must hold `req_valid` and its operands stable until granted.
- Arbitration: round-robin over `req_valid`, starting at pointer `ptr`.
  - After a grant to i, `ptr` becomes (i+1) mod REQ_CNT.
  - With no grant, `ptr` is unchanged.
  - Any continuously-valid requester is granted within REQ_CNT cycles.
- `hold`=1 forces `req_ready`=0 and leaves `ptr` unchanged.
- Issue register: on a grant, the granted `req_a`/`req_b` are registered into the `mo_mul` inputs.
  - On cycles with no grant, the operand registers hold their old value. The result of that slot is discarded.
- Tag pipe: depth 1+MUL_STAGE_CNT, entries {valid, id[$clog2(REQ_CNT)]}.
  - The tail gets {grant, granted id} every cycle.
  - Shifting is unconditional; the block never stalls.
- Response stage:
  - `rsp_valid[id]`=1 when the head entry is valid.
  - `rsp_data` = `mo_mul` result in the same cycle.
  - Requesters cannot backpressure and must sink the result.
- `busy` = OR of all tag-pipe valid bits.
- Arithmetic: no reduction or correction is applied here. The result equals `mo_mul` output, e.g. a·b·2^-DATA_WIDTH mod Q for Montgomery, or a·b·Q_K^KRED_L mod Q for K-RED, in `mo_mul`'s output range.

## Timing
- Latency from handshake cycle t to `rsp_valid` is exactly 1+MUL_STAGE_CNT cycles.
- Throughput is 1 product per cycle.
- Reset (`rst`=0, asynchronous):
  - all tag valids, `rsp_valid` and `busy` go to 0; `ptr` goes to 0.
  - `req_ready` = 0 while `rst`=0.
  - The operand registers clear to 0.
- Reset mid-operation: all in-flight products are dropped. No `rsp_valid` is asserted for any pre-reset request.
  - The first grant after release goes to the lowest valid index at or after 0.
- `hold` asserted while products are in flight: responses still appear at their scheduled cycles, and `busy` falls after the last one.
- Simultaneous grant and response: independent. A new grant never delays a response.
- `ptr` wrap-around: after a grant to REQ_CNT-1, `ptr` becomes 0.
- Single requester active: granted every cycle. Results are back-to-back, one per cycle.

## Structure
- Shared package holds:
  - `DATA_WIDTH`, `Q`, `MUL_STAGE_CNT`, `KRED_L`, `Q_K`, the `MULTYPE_KRED` selection;
  - a `mul_tag_t` typedef {logic valid; logic [ID_W-1:0] id}.
- Sub-module: one `mo_mul` instance, fed by the issue register.
- The round-robin pick is a function or `always_comb` inside this block; it gets no separate module.

## Test plan
- Single requester, default Q=3329, DATA_WIDTH=12: req 0 sends a=1, b=1 at cycle 0.
  - Expect `rsp_valid`=3'b001 at cycle 1+MUL_STAGE_CNT.
  - Expect (4096·`rsp_data`) mod 3329 = 1, or the K-RED equivalent.
- All three requesters valid continuously for 9 cycles with distinct operands.
  - Grants go 0,1,2,0,1,2,0,1,2.
  - Responses return in that order, each equal to its own a·b after domain correction.
- `hold` pulse: requesters 1 and 2 valid, `hold`=1 for cycles 3–5.
  - No grants in cycles 3–5.
  - Responses already in flight still appear on schedule.
  - `ptr` resumes at the same requester.
- Reset mid-flight: issue 4 requests, pull `rst` low for 1 cycle at cycle 2.
  - Zero `rsp_valid` pulses afterward; `busy`=0 immediately.
  - The next grant goes to the lowest valid index.
- Exhaustive sweep: requester 1 alone walks a, b over 0..Q-1.
  - Every response matches the golden a·b in the multiplier domain.
  - `rsp_valid` is continuous after fill.
